// File: rtl/snn_input_loader_if.sv
// Bundle of all handshake and bus signals around the SNN input loader:
// UART RX byte hand-off, input-RAM write/read port, snn_core start/done,
// and UART TX launch. The loader takes the master view. The surrounding
// blocks (or a testbench) take the slave view.
interface snn_input_loader_if #(
   parameter int ADDR_W = 10
);

   // UART RX side
   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic              rx_clr_rdy;

   // snn_core read address and input RAM port
   logic [ADDR_W-1:0] core_addr;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_data;
   logic              ram_we;

   // snn_core control and result
   logic              snn_start;
   logic              snn_done;
   logic [3:0]        digit;

   // UART TX side
   logic              tx_rdy;
   logic              tx_start;
   logic [7:0]        tx_data;

   // status
   logic              busy;

   modport master (
      input  rx_rdy,
      input  rx_data,
      input  core_addr,
      input  snn_done,
      input  digit,
      input  tx_rdy,
      output rx_clr_rdy,
      output ram_addr,
      output ram_data,
      output ram_we,
      output snn_start,
      output tx_start,
      output tx_data,
      output busy
   );

   modport slave (
      output rx_rdy,
      output rx_data,
      output core_addr,
      output snn_done,
      output digit,
      output tx_rdy,
      input  rx_clr_rdy,
      input  ram_addr,
      input  ram_data,
      input  ram_we,
      input  snn_start,
      input  tx_start,
      input  tx_data,
      input  busy
   );

endinterface

// File: rtl/snn_input_loader.sv
// Front-end controller for the SNN digit classifier.
// Collects NUM_PIXELS/8 packed UART bytes, unpacks each one LSB first into
// consecutive addresses of the 1-bit input RAM, pulses snn_start once the
// whole image is in, waits for snn_core to finish and then launches the
// classified digit on the UART transmitter. While snn_core is running it
// owns the RAM address; otherwise the loader's write pointer does.
module snn_input_loader #(
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_W     = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   snn_input_loader_if.master  bus
);

   typedef enum logic [2:0] {
      LOAD,
      UNPACK,
      START,
      RUN,
      TX
   } state_t;

   // Pointer value of the final pixel; the image is complete once the last
   // bit of a byte lands here.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_t            state;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        shreg;
   logic [2:0]        bit_cnt;
   logic [3:0]        digit_q;
   logic              snn_start_q;
   logic              tx_start_q;
   logic [7:0]        tx_data_q;

   // Main controller: byte intake, bit unpacking, core start/result capture
   // and TX launch. Pulse outputs default low and are raised for one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= LOAD;
         wr_addr     <= '0;
         shreg       <= 8'h00;
         bit_cnt     <= 3'd0;
         digit_q     <= 4'h0;
         snn_start_q <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= 8'h00;
      end else begin
         snn_start_q <= 1'b0;
         tx_start_q  <= 1'b0;
         case (state)
            LOAD: begin
               if (bus.rx_rdy) begin
                  shreg   <= bus.rx_data;
                  bit_cnt <= 3'd0;
                  state   <= UNPACK;
               end
            end
            UNPACK: begin
               shreg   <= {1'b0, shreg[7:1]};
               wr_addr <= wr_addr + ADDR_ONE;
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (wr_addr == LAST_ADDR) begin
                     snn_start_q <= 1'b1;
                     state       <= START;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            START: begin
               state <= RUN;
            end
            RUN: begin
               if (bus.snn_done) begin
                  digit_q <= bus.digit;
                  state   <= TX;
               end
            end
            TX: begin
               if (bus.tx_rdy) begin
                  tx_start_q <= 1'b1;
                  tx_data_q  <= {4'h0, digit_q};
                  wr_addr    <= '0;
                  state      <= LOAD;
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

   // The byte-consumed strobe has to coincide with the cycle the byte is
   // taken, so it is decoded from the current state rather than registered.
   assign bus.rx_clr_rdy = rst_n && (state == LOAD) && bus.rx_rdy;

   // RAM write port: one bit per UNPACK cycle at the write pointer. The
   // shift register is empty outside UNPACK, the gate just makes it explicit.
   assign bus.ram_we   = (state == UNPACK);
   assign bus.ram_data = (state == UNPACK) && shreg[0];

   // snn_core reads the RAM while it is started and running.
   assign bus.ram_addr = ((state == START) || (state == RUN)) ? bus.core_addr : wr_addr;

   // Remaining outputs come straight from registers.
   assign bus.snn_start = snn_start_q;
   assign bus.tx_start  = tx_start_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.busy      = (state != LOAD);

endmodule

// File: tb/tb_snn_input_loader.sv
// Self-checking bench for snn_input_loader. Random image bytes go in through
// a UART RX model; a byte-level reference model predicts every RAM write,
// every snn_start and every TX byte, and a negedge monitor checks the DUT
// against those predictions.
module tb_snn_input_loader;

   localparam int NUM_PIXELS = 784;
   localparam int ADDR_W     = 10;
   localparam int NUM_BYTES  = NUM_PIXELS / 8;
   localparam int START_LAT  = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   int         img_bytes   = 0;
   int         exp_starts  = 0;
   int         exp_writes[$];
   logic [7:0] exp_tx[$];
   logic [7:0] last_tx_byte = 8'h00;

   // monitor observations
   int   clr_count     = 0;
   int   last_clr_cyc  = 0;
   int   start_count   = 0;
   int   start_cyc     = 0;
   int   tx_count      = 0;
   int   tx_cyc        = 0;
   logic tx_busy       = 1'b0;
   bit   in_core       = 1'b0;
   int   writes_in_core = 0;
   int   clr_in_core    = 0;

   snn_input_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

   snn_input_loader #(
      .NUM_PIXELS (NUM_PIXELS),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // free-running clock and cycle index
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT presents a write, a TX
   // launch, a byte-consumed strobe or a start pulse
   always @(negedge clk) begin
      logic [31:0] act;
      logic [7:0]  etx;
      int          ew;
      if (bus_if.tx_start === 1'b1) begin
         tx_count++;
         tx_cyc  = cyc;
         tx_busy = bus_if.busy;
         in_core = 1'b0;
         if (exp_tx.size() == 0) begin
            checkOutput("unexpected_tx_start", 32'd1, 32'd0);
         end else begin
            etx = exp_tx.pop_front();
            checkOutput("tx_data", {24'h0, bus_if.tx_data}, {24'h0, etx});
         end
      end
      if (bus_if.ram_we === 1'b1) begin
         if (in_core) writes_in_core++;
         act = {21'h0, bus_if.ram_addr, bus_if.ram_data};
         if (exp_writes.size() == 0) begin
            checkOutput("unexpected_ram_write", act, 32'hFFFF_FFFF);
         end else begin
            ew = exp_writes.pop_front();
            checkOutput("ram_write_addr_data", act, ew);
         end
      end
      if (bus_if.rx_clr_rdy === 1'b1) begin
         clr_count++;
         last_clr_cyc = cyc;
         if (in_core) clr_in_core++;
      end
      if (bus_if.snn_start === 1'b1) begin
         start_count++;
         start_cyc = cyc;
         in_core   = 1'b1;
      end
   end

   // UART RX model: present one byte, wait for it to be consumed, then drop
   // rx_rdy. The reference model predicts the 8 writes for it.
   task automatic applyStimulus(input logic [7:0] b, input int budget);
      int  n;
      bit  found;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk);
      #1;
      bus_if.rx_rdy  = 1'b1;
      bus_if.rx_data = b;
      for (int i = 0; i < 8; i++) exp_writes.push_back((img_bytes * 8 + i) * 2 + int'(b[i]));
      img_bytes++;
      if (img_bytes == NUM_BYTES) begin
         img_bytes = 0;
         exp_starts++;
      end
      n     = 0;
      found = 1'b0;
      while (n < budget && !found) begin
         @(negedge clk);
         if (bus_if.rx_clr_rdy === 1'b1) found = 1'b1;
         n++;
      end
      if (!found) checkOutput("rx_clr_rdy_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus_if.rx_rdy  = 1'b0;
      bus_if.rx_data = 8'($urandom);
   endtask

   task automatic sendRandomBytes(input int n);
      for (int k = 0; k < n; k++) applyStimulus(8'($urandom), 40);
   endtask

   // wait for the start pulse of a completed image and check its latency
   task automatic waitStart();
      int prev;
      int n;
      prev = start_count;
      n    = 0;
      while (n < 40 && start_count == prev) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (start_count == prev) begin
         checkOutput("snn_start_timeout", 32'd0, 32'd1);
      end else begin
         checkOutput("start_latency", start_cyc - last_clr_cyc, START_LAT);
      end
   endtask

   // snn_core / UART TX model: exercise the address mux, report a digit and
   // accept the TX byte, optionally keeping the transmitter busy first
   task automatic runCore(input logic [3:0] d, input int tx_hold);
      logic [ADDR_W-1:0] ca;
      int                done_cyc;
      int                prev_tx;
      int                exp_cyc;
      int                n;
      bus_if.tx_rdy = (tx_hold == 0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         ca = ADDR_W'($urandom);
         bus_if.core_addr = ca;
         @(negedge clk);
         checkOutput("ram_addr_mux_run", {22'h0, bus_if.ram_addr}, {22'h0, ca});
         checkOutput("busy_run", {31'h0, bus_if.busy}, 32'd1);
      end
      @(posedge clk);
      #1;
      prev_tx         = tx_count;
      bus_if.snn_done = 1'b1;
      bus_if.digit    = d;
      done_cyc        = cyc;
      exp_tx.push_back({4'h0, d});
      @(posedge clk);
      #1;
      bus_if.snn_done = 1'b0;
      bus_if.digit    = 4'($urandom);
      if (tx_hold > 0) begin
         repeat (tx_hold) @(posedge clk);
         #1;
         checkOutput("tx_withheld", tx_count - prev_tx, 32'd0);
         checkOutput("tx_data_hold", {24'h0, bus_if.tx_data}, {24'h0, last_tx_byte});
         checkOutput("busy_tx_wait", {31'h0, bus_if.busy}, 32'd1);
         bus_if.tx_rdy = 1'b1;
         exp_cyc = cyc + 1;
      end else begin
         exp_cyc = done_cyc + 2;
      end
      n = 0;
      while (n < 20 && tx_count == prev_tx) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (tx_count == prev_tx) begin
         checkOutput("tx_start_timeout", 32'd0, 32'd1);
      end else begin
         checkOutput("tx_start_cycle", tx_cyc, exp_cyc);
         checkOutput("busy_at_tx_start", {31'h0, tx_busy}, 32'd0);
      end
      last_tx_byte = {4'h0, d};
      checkOutput("start_count", start_count, exp_starts);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ram_we"},    {31'h0, bus_if.ram_we},    32'd0);
      checkOutput({tag, "_ram_data"},  {31'h0, bus_if.ram_data},  32'd0);
      checkOutput({tag, "_ram_addr"},  {22'h0, bus_if.ram_addr},  32'd0);
      checkOutput({tag, "_snn_start"}, {31'h0, bus_if.snn_start}, 32'd0);
      checkOutput({tag, "_tx_start"},  {31'h0, bus_if.tx_start},  32'd0);
      checkOutput({tag, "_tx_data"},   {24'h0, bus_if.tx_data},   32'd0);
      checkOutput({tag, "_busy"},      {31'h0, bus_if.busy},      32'd0);
      checkOutput({tag, "_rx_clr"},    {31'h0, bus_if.rx_clr_rdy}, 32'd0);
   endtask

   // watchdog so a stuck DUT still ends the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // main sequence
   initial begin
      int clr_before;
      int ram_we_seen;
      bus_if.rx_rdy    = 1'b0;
      bus_if.rx_data   = 8'h00;
      bus_if.core_addr = '0;
      bus_if.snn_done  = 1'b0;
      bus_if.digit     = 4'h0;
      bus_if.tx_rdy    = 1'b1;

      // power-on reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // image 1: first byte 0xA5 consumed exactly once, then a full image
      clr_before = clr_count;
      applyStimulus(8'hA5, 40);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("clr_first_byte", clr_count - clr_before, 32'd1);
      sendRandomBytes(NUM_BYTES - 1);
      waitStart();
      runCore(4'd6, 0);

      // image 2: stray snn_done while loading, then TX kept busy 50 cycles
      sendRandomBytes(10);
      @(posedge clk);
      #1;
      bus_if.snn_done = 1'b1;
      bus_if.digit    = 4'd3;
      @(posedge clk);
      #1;
      bus_if.snn_done = 1'b0;
      sendRandomBytes(NUM_BYTES - 10);
      waitStart();
      runCore(4'd9, 50);

      // image 3: a byte arrives while the core runs; it must wait for TX
      sendRandomBytes(NUM_BYTES);
      waitStart();
      writes_in_core = 0;
      clr_in_core    = 0;
      fork
         applyStimulus(8'($urandom), 200);
         runCore(4'($urandom_range(0, 9)), 0);
      join
      checkOutput("no_write_in_core", writes_in_core, 32'd0);
      checkOutput("no_clr_in_core", clr_in_core, 32'd0);
      checkOutput("pending_byte_taken_at_tx", last_clr_cyc, tx_cyc);

      // image 4: rest of the image started by the pending byte
      sendRandomBytes(NUM_BYTES - 1);
      waitStart();
      runCore(4'($urandom_range(0, 9)), $urandom_range(0, 5));

      // reset part-way through an image, then a clean reload
      sendRandomBytes(40);
      repeat (12) @(posedge clk);
      #1;
      checkOutput("writes_drained", exp_writes.size(), 32'd0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("mid_rst");
      img_bytes    = 0;
      exp_writes.delete();
      in_core      = 1'b0;
      last_tx_byte = 8'h00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ram_we_seen = int'(bus_if.ram_we);
      checkOutput("idle_after_reset", ram_we_seen, 32'd0);
      sendRandomBytes(NUM_BYTES);
      waitStart();
      runCore(4'($urandom_range(0, 9)), 0);

      // everything predicted must have been seen
      repeat (5) @(posedge clk);
      #1;
      checkOutput("tx_data_after_launch", {24'h0, bus_if.tx_data}, {24'h0, last_tx_byte});
      checkOutput("writes_left", exp_writes.size(), 32'd0);
      checkOutput("tx_left", exp_tx.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
